// File: rtl/axi_slave_mem.sv
// AXI4 slave responder backed by a single-port word-addressed SRAM port.
// Serves one read or write burst at a time; INCR/FIXED bursts, WRAP handled as INCR.
//
// state | meaning
// IDLE  | waiting for an address; grant alternates when aw and ar arrive together
// WDATA | accepting write beats, one SRAM write per beat
// WRESP | presenting the write response until bready
// RREQ  | issuing the SRAM read for the current beat
// RDATA | presenting read data until rready
module axi_slave_mem #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 64,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [1:0]          rresp,
  output logic [DATA_W-1:0]   rdata,
  output logic                rlast,
  output logic                mem_cen,
  output logic                mem_wen,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'd1 << (MEM_AW + 3);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLV  = 2'b10;
  localparam logic [1:0]  RESP_DEC  = 2'b11;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RDATA} state_t;

  state_t            state, state_nxt;
  logic              grant_wr;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       addr_q;
  logic [31:0]       addr_nxt;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_cur;
  logic              rd_first;
  logic              is_last;

  function automatic logic [1:0] accept_err(input logic [31:0] a, input logic [2:0] s);
    if (a >= MEM_LIMIT) return RESP_DEC;
    if (s > 3'd3)       return RESP_SLV;
    return RESP_OKAY;
  endfunction

  assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
  assign is_last   = (beat_q == len_q);
  assign rdata_cur = (err_q != RESP_OKAY) ? '0 : mem_rdata;

  assign bid       = id_q;
  assign bresp     = err_q;
  assign rid       = id_q;
  assign rresp     = err_q;
  assign rlast     = is_last;
  // SRAM output is only guaranteed in the first RDATA cycle; a stall replays the captured copy.
  assign rdata     = rd_first ? rdata_cur : rdata_q;
  assign mem_addr  = addr_q[MEM_AW+2:3];
  assign mem_wdata = wdata;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      grant_wr <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      err_q    <= RESP_OKAY;
      rdata_q  <= '0;
      rd_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_first <= (state == RREQ);
      case (state)
        IDLE: begin
          if (awvalid && awready) begin
            id_q     <= awid;
            addr_q   <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            beat_q   <= '0;
            err_q    <= accept_err(awaddr, awsize);
            grant_wr <= 1'b0;
          end else if (arvalid && arready) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            beat_q   <= '0;
            err_q    <= accept_err(araddr, arsize);
            grant_wr <= 1'b1;
          end
        end
        WDATA: begin
          if (wvalid) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= addr_nxt;
            if (!wlast && is_last) begin
              if (err_q == RESP_OKAY) err_q <= RESP_SLV;
            end else if (!wlast && addr_nxt >= MEM_LIMIT) begin
              if (err_q == RESP_OKAY) err_q <= RESP_DEC;
            end
          end
        end
        RDATA: begin
          if (rd_first) rdata_q <= rdata_cur;
          if (rready && !is_last) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= addr_nxt;
            if (addr_nxt >= MEM_LIMIT && err_q == RESP_OKAY) err_q <= RESP_DEC;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_wmask = '0;
    for (int i = 0; i < DATA_W/8; i++) mem_wmask[i*8 +: 8] = {8{wstrb[i]}};
    case (state)
      IDLE: begin
        awready = awvalid && (!arvalid || grant_wr);
        arready = arvalid && (!awvalid || !grant_wr);
        if (awready)      state_nxt = WDATA;
        else if (arready) state_nxt = RREQ;
      end
      WDATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_cen = (err_q == RESP_OKAY);
          mem_wen = (err_q == RESP_OKAY);
          if (wlast || is_last) state_nxt = WRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      RREQ: begin
        mem_cen   = (err_q == RESP_OKAY);
        state_nxt = RDATA;
      end
      RDATA: begin
        rvalid = 1'b1;
        if (rready) state_nxt = is_last ? IDLE : RREQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem with a behavioural SRAM behind the memory port.
module tb_axi_slave_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        rlast;
  logic        mem_cen, mem_wen;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_wmask, mem_rdata;

  logic [63:0] sram [1024];
  int          cen_count = 0;
  int          n_asserts = 0;
  int          n_fail = 0;

  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id;
  logic [1:0]  b_resp_s;
  logic [3:0]  b_id_s;
  logic [63:0] snap_data;
  int          snap_cen;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_cen) begin
      cen_count <= cen_count + 1;
      if (mem_wen) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else         mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin tick(); n++; end
    chk("aw_handshake", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin tick(); n++; end
    chk("ar_handshake", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
    #1;
    while (!wready && n < 20) begin tick(); n++; end
    chk("wready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait();
    int n = 0;
    bready = 1'b1;
    #1;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("bvalid", bvalid, 1);
    b_resp_s = bresp; b_id_s = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic r_beats(input int len);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      rready = 1'b1;
      #1;
      while (!rvalid && n < 20) begin tick(); n++; end
      chk("rvalid", rvalid, 1);
      rd_data[i] = rdata; rd_last[i] = rlast; rd_resp[i] = rresp; rd_id = rid;
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; mem_rdata = 0;
    for (int i = 0; i < 1024; i++) sram[i] = 64'h0;
    do_reset();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_cen", mem_cen, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);

    // single beat write / read
    aw_req(4'd3, 32'h0, 8'd0, 3'd3, 2'b01);
    w_beat(64'h1122334455667788, 8'hFF, 1'b1);
    b_wait();
    chk("single_bresp", b_resp_s, 2'b00);
    chk("single_bid", b_id_s, 4'd3);
    ar_req(4'd5, 32'h0, 8'd0, 3'd3, 2'b01);
    r_beats(0);
    chk("single_rdata", rd_data[0], 64'h1122334455667788);
    chk("single_rlast", rd_last[0], 1);
    chk("single_rid", rd_id, 4'd5);
    chk("single_rresp", rd_resp[0], 2'b00);

    // INCR burst of four
    aw_req(4'd1, 32'h40, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(64'(i + 1), 8'hFF, i == 3);
    b_wait();
    chk("incr_bresp", b_resp_s, 2'b00);
    chk("incr_sram_word9", sram[9], 64'd2);
    ar_req(4'd2, 32'h40, 8'd3, 3'd3, 2'b01);
    r_beats(3);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd_data[i], 64'(i + 1));
      chk("incr_rlast", rd_last[i], i == 3);
    end

    // partial strobe
    aw_req(4'd1, 32'h80, 8'd0, 3'd3, 2'b01);
    w_beat(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    b_wait();
    aw_req(4'd1, 32'h80, 8'd0, 3'd3, 2'b01);
    w_beat(64'h0, 8'h0F, 1'b1);
    b_wait();
    ar_req(4'd1, 32'h80, 8'd0, 3'd3, 2'b01);
    r_beats(0);
    chk("strb_rdata", rd_data[0], 64'hFFFFFFFF00000000);

    // rready stall on beat 2 of a three-beat read
    ar_req(4'd9, 32'h40, 8'd2, 3'd3, 2'b01);
    r_beats(0);
    chk("stall_beat0", rd_data[0], 64'd1);
    begin
      int n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
    end
    chk("stall_rvalid", rvalid, 1);
    snap_data = rdata;
    snap_cen = cen_count;
    chk("stall_first", snap_data, 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rdata", rdata, 64'd2);
      chk("stall_rid", rid, 4'd9);
    end
    chk("stall_no_cen", 64'(cen_count), 64'(snap_cen));
    rready = 1'b1;
    #1;
    chk("stall_rlast_mid", rlast, 0);
    tick();
    rready = 1'b0;
    r_beats(0);
    chk("stall_beat2", rd_data[0], 64'd3);
    chk("stall_rlast_end", rd_last[0], 1);

    // out-of-range and bad-size transactions
    snap_cen = cen_count;
    ar_req(4'd4, 32'h0001_0000, 8'd1, 3'd3, 2'b01);
    r_beats(1);
    chk("dec_rresp0", rd_resp[0], 2'b11);
    chk("dec_rresp1", rd_resp[1], 2'b11);
    chk("dec_rdata0", rd_data[0], 64'h0);
    chk("dec_rdata1", rd_data[1], 64'h0);
    chk("dec_rlast", rd_last[1], 1);
    aw_req(4'd6, 32'h0001_0000, 8'd0, 3'd3, 2'b01);
    w_beat(64'hDEAD, 8'hFF, 1'b1);
    b_wait();
    chk("dec_bresp", b_resp_s, 2'b11);
    aw_req(4'd6, 32'h0, 8'd0, 3'd4, 2'b01);
    w_beat(64'hBEEF, 8'hFF, 1'b1);
    b_wait();
    chk("slv_bresp", b_resp_s, 2'b10);
    chk("err_no_cen", 64'(cen_count), 64'(snap_cen));
    chk("slv_sram0", sram[0], 64'h1122334455667788);

    // reset during write beat 2
    aw_req(4'd7, 32'h100, 8'd3, 3'd3, 2'b01);
    w_beat(64'hA, 8'hFF, 1'b0);
    w_beat(64'hB, 8'hFF, 1'b0);
    wvalid = 1'b1; wdata = 64'hC; wstrb = 8'hFF;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    wvalid = 1'b0;
    #1;
    chk("rstmid_bvalid", bvalid, 0);
    chk("rstmid_wready", wready, 0);
    awid = 4'd8; awaddr = 32'h100; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    #1;
    chk("rstmid_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    w_beat(64'hABCD, 8'hFF, 1'b1);
    b_wait();
    chk("rstmid_bresp", b_resp_s, 2'b00);
    chk("rstmid_bid", b_id_s, 4'd8);
    ar_req(4'd8, 32'h100, 8'd0, 3'd3, 2'b01);
    r_beats(0);
    chk("rstmid_rdata", rd_data[0], 64'hABCD);

    // simultaneous aw/ar: write first, then read
    do_reset();
    awid = 4'd1; awaddr = 32'h200; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd2; araddr = 32'h40;  arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("grant1_awready", awready, 1);
    chk("grant1_arready", arready, 0);
    tick();
    awvalid = 1'b0;
    w_beat(64'h55, 8'hFF, 1'b1);
    b_wait();
    awaddr = 32'h208; awvalid = 1'b1;
    #1;
    chk("grant2_arready", arready, 1);
    chk("grant2_awready", awready, 0);
    tick();
    arvalid = 1'b0;
    r_beats(0);
    chk("grant2_rdata", rd_data[0], 64'd1);
    chk("grant2_rid", rd_id, 4'd2);
    #1;
    chk("grant3_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    w_beat(64'h66, 8'hFF, 1'b1);
    b_wait();
    chk("grant3_sram", sram[65], 64'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
